// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT output reorder buffer: input samples from
// the FFT core and the reordered output stream with its frame markers.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 11
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] InRe;
  logic signed [DATA_W-1:0] InIm;
  logic                     out_valid;
  logic signed [DATA_W-1:0] OutRe;
  logic signed [DATA_W-1:0] OutIm;
  logic                     out_first;
  logic                     out_last;

  modport master (
    output in_valid, InRe, InIm,
    input  out_valid, OutRe, OutIm, out_first, out_last
  );

  modport slave (
    input  in_valid, InRe, InIm,
    output out_valid, OutRe, OutIm, out_first, out_last
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: converts each N-point FFT frame from bit-reversed
// to natural order (or plain frame delay) at one sample per clock, no stall.
module fft_bitrev_reorder #(
  parameter int DATA_W = 11,
  parameter int LOG2N  = 5,
  parameter bit BITREV = 1'b1
) (
  input logic                  clk,
  input logic                  i_rst,
  fft_bitrev_reorder_if.slave  bus
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [2*DATA_W-1:0] mem [2*N];

  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank;
  logic [1:0]       full;
  logic             fill_done;

  logic [0:0]       state;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;

  logic             issue;
  logic             iss_bank;
  logic [LOG2N-1:0] iss_cnt;
  logic             iss_end;
  logic             chain;
  logic [2*DATA_W-1:0] rd_word;

  always_comb begin
    wr_addr = wr_cnt;
    if (BITREV) begin
      for (int unsigned i = 0; i < LOG2N; i++) begin
        wr_addr[i] = wr_cnt[LOG2N-1-i];
      end
    end
  end

  assign fill_done = bus.in_valid && (wr_cnt == CNT_LAST);

  // IDLE issues index 0 on the same edge it leaves, so the first output lands
  // one cycle after the bank fills; STREAM then continues from rd_cnt.
  always_comb begin
    issue    = 1'b0;
    iss_bank = rd_bank;
    iss_cnt  = rd_cnt;
    if (state == STREAM) begin
      issue = 1'b1;
    end else begin
      issue    = |full;
      iss_bank = (&full) ? wr_bank : full[1];
      iss_cnt  = '0;
    end
  end

  assign iss_end = issue && (iss_cnt == CNT_LAST);
  assign chain   = full[~iss_bank] || (fill_done && (wr_bank != iss_bank));
  assign rd_word = mem[{iss_bank, iss_cnt}];

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem[{wr_bank, wr_addr}] <= {bus.InRe, bus.InIm};
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      full          <= '0;
      state         <= IDLE;
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.OutRe     <= '0;
      bus.OutIm     <= '0;
    end else begin
      if (bus.in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (fill_done) begin
          wr_bank <= ~wr_bank;
        end
      end

      // A clear and a set on the same edge always target different banks.
      full[0] <= (full[0] && !(iss_end && !iss_bank)) || (fill_done && !wr_bank);
      full[1] <= (full[1] && !(iss_end &&  iss_bank)) || (fill_done &&  wr_bank);

      bus.out_valid <= issue;
      bus.out_first <= issue && (iss_cnt == '0);
      bus.out_last  <= iss_end;
      if (issue) begin
        bus.OutRe <= rd_word[2*DATA_W-1:DATA_W];
        bus.OutIm <= rd_word[DATA_W-1:0];
        if (iss_end) begin
          if (chain) begin
            state   <= STREAM;
            rd_bank <= ~iss_bank;
            rd_cnt  <= '0;
          end else begin
            state   <= IDLE;
          end
        end else begin
          state   <= STREAM;
          rd_bank <= iss_bank;
          rd_cnt  <= iss_cnt + 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!i_rst && bus.in_valid) begin
      assert (!full[wr_bank])
        else $error("write into bank %0d while it is still full", wr_bank);
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: a 32-point reordering instance and
// an 8-point passthrough instance, checked cycle by cycle against a queue.
module tb_fft_bitrev_reorder;

  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_W(DW)) a_if ();
  fft_bitrev_reorder_if #(.DATA_W(DW)) b_if ();

  fft_bitrev_reorder #(.DATA_W(DW), .LOG2N(5), .BITREV(1'b1)) dut_a (
    .clk   (clk),
    .i_rst (rst),
    .bus   (a_if.slave)
  );

  fft_bitrev_reorder #(.DATA_W(DW), .LOG2N(3), .BITREV(1'b0)) dut_b (
    .clk   (clk),
    .i_rst (rst),
    .bus   (b_if.slave)
  );

  typedef struct {
    int due;
    int re;
    int im;
    bit first;
    bit last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   a_re[32], a_im[32], a_n = 0;
  int   b_re[8],  b_im[8],  b_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bitrev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++)
      if ((v >> i) & 1) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  // Output index k is due two negedges after the last input is driven, plus k.
  task automatic drive_a(input bit v, input int re, input int im);
    exp_t e;
    @(negedge clk);
    a_if.in_valid = v;
    a_if.InRe     = DW'(re);
    a_if.InIm     = DW'(im);
    if (v) begin
      a_re[a_n] = re;
      a_im[a_n] = im;
      a_n++;
      if (a_n == 32) begin
        for (int k = 0; k < 32; k++) begin
          e.due   = cyc + 2 + k;
          e.re    = a_re[bitrev(k, 5)];
          e.im    = a_im[bitrev(k, 5)];
          e.first = (k == 0);
          e.last  = (k == 31);
          qa.push_back(e);
        end
        a_n = 0;
      end
    end
  endtask

  task automatic drive_b(input bit v, input int re, input int im);
    exp_t e;
    @(negedge clk);
    b_if.in_valid = v;
    b_if.InRe     = DW'(re);
    b_if.InIm     = DW'(im);
    if (v) begin
      b_re[b_n] = re;
      b_im[b_n] = im;
      b_n++;
      if (b_n == 8) begin
        for (int k = 0; k < 8; k++) begin
          e.due   = cyc + 2 + k;
          e.re    = b_re[k];
          e.im    = b_im[k];
          e.first = (k == 0);
          e.last  = (k == 7);
          qb.push_back(e);
        end
        b_n = 0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    bit   ev;
    ev = (qa.size() != 0) && (qa[0].due == cyc);
    check("a_valid", int'(a_if.out_valid), int'(ev));
    if (ev) begin
      e = qa.pop_front();
      check("a_re",    int'(a_if.OutRe),     e.re);
      check("a_im",    int'(a_if.OutIm),     e.im);
      check("a_first", int'(a_if.out_first), int'(e.first));
      check("a_last",  int'(a_if.out_last),  int'(e.last));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    bit   ev;
    ev = (qb.size() != 0) && (qb[0].due == cyc);
    check("b_valid", int'(b_if.out_valid), int'(ev));
    if (ev) begin
      e = qb.pop_front();
      check("b_re",    int'(b_if.OutRe),     e.re);
      check("b_im",    int'(b_if.OutIm),     e.im);
      check("b_first", int'(b_if.out_first), int'(e.first));
      check("b_last",  int'(b_if.out_last),  int'(e.last));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, gaps, v;
    a_if.in_valid = 1'b0; a_if.InRe = '0; a_if.InIm = '0;
    b_if.in_valid = 1'b0; b_if.InRe = '0; b_if.InIm = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", int'(a_if.out_valid), 0);
    check("rst_re",    int'(a_if.OutRe),     0);
    check("rst_im",    int'(a_if.OutIm),     0);
    check("rst_first", int'(a_if.out_first), 0);
    check("rst_last",  int'(a_if.out_last),  0);
    check("rst_b_val", int'(b_if.out_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single frame, bit-reversed input gives natural-order ramp
    for (j = 0; j < 32; j++) begin
      k = bitrev(j, 5);
      drive_a(1'b1, k, -k);
    end
    drive_a(1'b0, 0, 0);
    wait_drain();

    // 2: two back-to-back frames, second offset by 100
    for (int f = 0; f < 2; f++)
      for (j = 0; j < 32; j++) begin
        k = bitrev(j, 5);
        drive_a(1'b1, k + 100 * f, -k + 100 * f);
      end
    drive_a(1'b0, 0, 0);
    wait_drain();

    // 3: random input gaps
    j = 0;
    gaps = 0;
    while (j < 32) begin
      v = $urandom_range(0, 1);
      if (v != 0 || gaps >= 3) begin
        k = bitrev(j, 5);
        drive_a(1'b1, k, -k);
        j++;
        gaps = 0;
      end else begin
        drive_a(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
        gaps++;
      end
    end
    drive_a(1'b0, 0, 0);
    wait_drain();

    // 4: async reset while a frame streams and the next is 17 samples in
    for (j = 0; j < 32; j++) drive_a(1'b1, 500 + j, -500 - j);
    for (j = 0; j < 17; j++) drive_a(1'b1, 300 + j, -300 - j);
    @(posedge clk);
    #2;
    rst = 1'b1;
    a_if.in_valid = 1'b0;
    qa.delete();
    qb.delete();
    a_n = 0;
    b_n = 0;
    #1;
    check("arst_valid", int'(a_if.out_valid), 0);
    check("arst_re",    int'(a_if.OutRe),     0);
    check("arst_im",    int'(a_if.OutIm),     0);
    check("arst_first", int'(a_if.out_first), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (j = 0; j < 32; j++) begin
      k = bitrev(j, 5);
      drive_a(1'b1, k + 7, -k - 7);
    end
    drive_a(1'b0, 0, 0);
    wait_drain();

    // 5: passthrough 8-point instance
    for (j = 0; j < 8; j++) drive_b(1'b1, 10 + j, -10 - j);
    drive_b(1'b0, 0, 0);
    wait_drain();

    // 6: extreme values, signs preserved
    for (j = 0; j < 32; j++) begin
      case (j % 4)
        0:       drive_a(1'b1, -1024, 1023);
        1:       drive_a(1'b1, 1023, -1024);
        default: drive_a(1'b1, int'($urandom_range(0, 2047)) - 1024,
                         int'($urandom_range(0, 2047)) - 1024);
      endcase
    end
    drive_a(1'b0, 0, 0);
    for (j = 0; j < 8; j++) drive_b(1'b1, (j % 2 == 0) ? -1024 : 1023, (j % 2 == 0) ? 1023 : -1024);
    drive_b(1'b0, 0, 0);
    wait_drain();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Parametrised output reorder buffer placed directly after the MDC FFT core's serial output (FFTOutRe/FFTOutIm, FFT_out_valid).
- Converts each N-point frame from bit-reversed order to natural order, so downstream logic and file dumps see X[0]..X[N-1].
- Double-buffered (ping-pong), so it sustains back-to-back frames at one sample per clock with no stall.
- Generalises the fixed 32-point, single-order path to any power-of-two N, any data width, and a selectable passthrough mode.

Parameters:
- DATA_W, 11, signed width of each real/imag sample in and out
- LOG2N, 5, log2 of frame length N (N = 2^LOG2N, LOG2N in 2..10)
- BITREV, 1, 1 = write at bit-reversed address (reorder); 0 = write at natural address (pure frame delay, same latency)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- in_valid  in  1  InRe/InIm carry a sample this cycle
- InRe  in  DATA_W  signed real input sample
- InIm  in  DATA_W  signed imag input sample
- out_valid  out  1  OutRe/OutIm valid this cycle
- OutRe  out  DATA_W  signed real output sample (registered)
- OutIm  out  DATA_W  signed imag output sample (registered)
- out_first  out  1  high with output index 0 of a frame
- out_last  out  1  high with output index N-1 of a frame

Behaviour:
- Reset: asynchronous, active-high on i_rst. While asserted and after release: out_valid=0, out_first=0, out_last=0, OutRe=0, OutIm=0, wr_cnt=0, wr_bank=0, both bank-full flags=0, read FSM=IDLE. Memory contents are don't-care.
- Storage: two banks × N entries × 2·DATA_W bits; register-file style, synchronous write.
- Write side:
  - On each clock with in_valid=1, store (InRe,InIm) in bank wr_bank at address bitrev(wr_cnt), or wr_cnt when BITREV=0. LOG2N-bit reversal.
  - wr_cnt increments and wraps N-1→0. Gaps (in_valid=0) hold wr_cnt.
  - On the write with wr_cnt=N-1: set full[wr_bank] and toggle wr_bank.
- Read FSM:
  - States IDLE and STREAM, with rd_bank and rd_cnt (LOG2N bits).
  - IDLE → STREAM when any full flag is set. rd_bank = the full bank (the older one if both), rd_cnt=0.
  - STREAM: every clock, register bank[rd_bank][rd_cnt] onto OutRe/OutIm, out_valid=1, out_first=(rd_cnt==0), out_last=(rd_cnt==N-1), then rd_cnt++.
  - After issuing rd_cnt=N-1: clear full[rd_bank]. If full[~rd_bank] is set (or is being set this same edge), stay in STREAM with rd_bank toggled and rd_cnt=0; otherwise go to IDLE.
  - Output is never stalled. Once out_valid rises, exactly N consecutive valid cycles follow.
- Latency:
  - Last input of a frame sampled at edge t → OutRe/OutIm index 0 valid after edge t+1 (one cycle).
  - Index k is valid after edge t+1+k.
  - With continuous input, frames emerge back-to-back with no gap.
- Overflow is structurally impossible: a bank fill takes ≥N cycles, and a drain takes exactly N cycles starting one cycle after the fill. The implementation includes a simulation-only assertion that wr_bank is never written while its full flag is set.
- Simultaneous events: a clear of full[x] and a set of full[y] on the same edge are independent (x≠y by construction). Same-cycle write to bank A and read from bank B is always allowed.
- Values pass through bit-exact: no rounding, no saturation, sign preserved.
- Reset mid-frame: the partial frame is discarded, and any frame being streamed is truncated (out_valid drops with reset). After release the first N valid inputs form a new frame.
- When not streaming, OutRe/OutIm hold their last value; consumers qualify data with out_valid.

Test Plan:
1. LOG2N=5, BITREV=1, 32 continuous inputs Re=k, Im=-k, written in bit-reversed order (in index j carries k=bitrev(j)) → out_valid for 32 cycles starting 1 cycle after the last input, Re=0,1,…,31, Im=0,-1,…,-31; out_first on Re=0, out_last on Re=31.
2. Two frames back-to-back (64 continuous inputs, frame 2 = frame 1 + 100) → 64 contiguous out_valid cycles, no bubble; out_first at output cycles 0 and 32.
3. Frame with random in_valid gaps (≈50% duty) → same output sequence as scenario 1, first output exactly 1 cycle after the 32nd accepted input.
4. Assert i_rst asynchronously (mid-cycle) after 17 inputs, release, then send a full frame → outputs go to 0 immediately; only the new frame is emitted, with correct order.
5. BITREV=0, LOG2N=3, inputs Re=10..17 → Re=10..17 in the same order, 1-cycle latency after the 8th input.
6. Extreme values DATA_W=11: inputs -1024 and +1023 at various indices → emitted bit-exact with sign preserved.
